cgra_prog_loader: RTL
=====================

# cgra_prog_loader

Programming-side transmitter for the CGRA tile instruction load path. It accepts one tile's full instruction image as 64-bit words over a valid/ready handshake and buffers the whole image internally. It then streams the image bit-serially to the selected tile by driving that tile's `program_mode` and serial program data. The stream is uninterrupted because the tile consumes one bit on every clock while `program_mode` is high. The block sits between the host/debug front end and the tile array.

## Interface
- `NUM_TILES`, 4: number of tiles driven; width of `program_mode`.
- `WORD_W`, 64: instruction word width in bits.
- `WORDS_PER_TILE`, 64: instruction words per tile image.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begins a load; sampled only in IDLE.
- `tile_sel`  in  clog2(NUM_TILES)  target tile; latched on accepted `start`.
- `bcast`  in  1  broadcast request; latched on accepted `start` (see Configuration).
- `abort`  in  1  cancels a load in progress.
- `word_data`  in  WORD_W  instruction word.
- `word_valid`  in  1  `word_data` valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `busy`  out  1  high in FILL and STREAM.
- `done`  out  1  one-cycle pulse when a stream completes.
- `program_mode`  out  NUM_TILES  per-tile programming enable, one-hot (all ones on broadcast).
- `jtag_data_out`  out  1  serial program bit, shared by all tiles.

## Operation
- Image buffer: WORDS_PER_TILE x WORD_W storage with a word counter `wcnt` and a bit counter `bcnt` (clog2(WORDS_PER_TILE*WORD_W) bits).
- States and transitions:
  - IDLE → FILL: `start` is high and `tile_sel` < NUM_TILES. An out-of-range `tile_sel` ignores `start`. On the transition, clear `wcnt` and latch `tile_sel`/`bcast`.
  - FILL:
    - `word_ready`=1.
    - On `word_valid && word_ready`, store to buffer[`wcnt`] and increment `wcnt`.
    - Gaps in `word_valid` are allowed.
    - Acceptance of word WORDS_PER_TILE-1 → STREAM with `bcnt`=0.
  - STREAM:
    - `word_ready`=0.
    - `jtag_data_out` = buffer[`bcnt`/WORD_W][`bcnt`%WORD_W]. This sends word 0 first and bit 0 first within each word. It matches the tile's storage of incoming bit n at word n/64, bit n%64.
    - The selected `program_mode` bit is held at 1.
    - After bit WORDS_PER_TILE*WORD_W-1 → IDLE, pulse `done`, drop `program_mode`.
- `program_mode` never deasserts mid-stream except on `abort`/`rst`. A deassertion rewinds the tile's write address, so the host must reload.
- `abort` in FILL or STREAM → IDLE next edge, `program_mode`=0, no `done`. `abort` in IDLE has no effect.
- `start` outside IDLE is ignored. `abort` and `start` in the same IDLE cycle: `start` wins.
- Reset values: `word_ready`=0, `busy`=0, `done`=0, `program_mode`=0, `jtag_data_out`=0, state IDLE, counters 0. Buffer contents are not reset.
- `rst` mid-operation behaves like `abort`, and additionally clears `done`.

## Timing
- `start` at edge T: FILL from T+1, with `word_ready`=1 in cycle T+1.
- Last word accepted at edge L: from L+1, `program_mode[sel]`=1 and `jtag_data_out`=bit 0. Both outputs are registers with no combinational path from inputs.
- Bit k is presented in cycle L+1+k; the tile samples it at the edge ending that cycle.
- `program_mode` stays high for exactly WORDS_PER_TILE*WORD_W cycles (4096 by default).
- `done`=1 and `program_mode`=0 in cycle L+4097. `busy`=0 in the same cycle. `start` is accepted from that cycle.
- Minimum load: 1 + 64 + 4096 cycles.

## Configuration
- `PROG_LOADER_BCAST_EN`:
  - Defined: a latched `bcast`=1 drives all NUM_TILES bits of `program_mode` high during STREAM, so every tile receives the same image. `tile_sel` range check is skipped when `bcast`=1.
  - Undefined: `bcast` is ignored and only `program_mode[tile_sel]` is driven.

## Test plan
- Basic load: `tile_sel`=2, words k = {32'hA5A5_0000 + k, 32'h0000_0000 + k} for k = 0..63. Required: `program_mode`=4'b0100 for exactly 4096 cycles. The deserialized stream equals the words, LSB-first, word 0 first. `done` pulses once, one cycle after the last bit.
- Handshake gaps: `word_valid` toggled 1/0 every cycle. Required: 64 words accepted over 128 cycles, no word lost or duplicated, stream identical to the basic case.
- Abort in STREAM at bit 1000: `program_mode` is 0 on the next cycle, `done` never pulses, `busy`=0. A subsequent `start` accepted in IDLE loads normally.
- Reset during FILL after 10 words: all outputs 0 next cycle, `word_ready`=0. A new full load completes with 64 fresh words.
- Illegal/ignored starts: `start` pulsed during STREAM changes nothing. With NUM_TILES=3, `tile_sel`=3 leaves the loader in IDLE and `busy`=0.
- With `PROG_LOADER_BCAST_EN` defined: `bcast`=1 gives `program_mode`=4'b1111 for 4096 cycles. Without the macro, the same stimulus gives only `program_mode[tile_sel]` high.

Source files
------------

// File: rtl/cgra_prog_loader.sv
// cgra_prog_loader
// Buffers one tile's instruction image (WORDS_PER_TILE x WORD_W) received over a valid/ready
// handshake, then streams it bit-serially to the selected tile. The stream sends word 0 first
// and bit 0 first within each word, one bit per clock, while program_mode is held high.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          begin a load (IDLE only); tile_sel_i / bcast_i latched on acceptance
//   tile_sel_i       target tile index
//   bcast_i          broadcast request (only honoured with PROG_LOADER_BCAST_EN defined)
//   abort_i          cancel a load in FILL or STREAM
//   word_data_i      instruction word
//   word_valid_i     word_data_i valid
//   word_ready_o     loader accepts a word this cycle (FILL)
//   busy_o           high in FILL and STREAM
//   done_o           one-cycle pulse when a stream completes
//   program_mode_o   per-tile programming enable (one-hot, all ones on broadcast)
//   jtag_data_out_o  serial program bit shared by all tiles
//
// Optional feature: define PROG_LOADER_BCAST_EN to let a latched bcast_i drive every
// program_mode bit. WORD_W and WORDS_PER_TILE must be powers of two, WORDS_PER_TILE >= 2.
module cgra_prog_loader #(
    parameter int unsigned NUM_TILES      = 4,
    parameter int unsigned WORD_W         = 64,
    parameter int unsigned WORDS_PER_TILE = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [$clog2(NUM_TILES)-1:0] tile_sel_i,
    input  logic                         bcast_i,
    input  logic                         abort_i,
    input  logic [WORD_W-1:0]            word_data_i,
    input  logic                         word_valid_i,
    output logic                         word_ready_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NUM_TILES-1:0]         program_mode_o,
    output logic                         jtag_data_out_o
);

    localparam int unsigned SelW  = $clog2(NUM_TILES);
    localparam int unsigned WcntW = $clog2(WORDS_PER_TILE);
    localparam int unsigned BitW  = $clog2(WORD_W);
    localparam int unsigned BcntW = $clog2(WORDS_PER_TILE * WORD_W);

    localparam logic [WcntW-1:0] LastWord = WcntW'(WORDS_PER_TILE - 1);
    localparam logic [BcntW-1:0] LastBit  = BcntW'(WORDS_PER_TILE * WORD_W - 1);

    typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

    state_e             state_q;
    logic [WcntW-1:0]   wcnt_q;
    logic [BcntW-1:0]   bcnt_q;
    logic [SelW-1:0]    sel_q;
    logic               word_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [NUM_TILES-1:0] pm_q;
    logic               jtag_q;

    logic [WORD_W-1:0]  buf_q [WORDS_PER_TILE];

    logic               sel_in_range;
    logic               start_ok;
    logic [NUM_TILES-1:0] stream_mask;
    logic [BcntW-1:0]   bcnt_nxt;
    logic [WcntW-1:0]   nxt_word;
    logic [BitW-1:0]    nxt_bit;

    assign sel_in_range = {1'b0, tile_sel_i} < (SelW + 1)'(NUM_TILES);

`ifdef PROG_LOADER_BCAST_EN
    logic bcast_q;

    // Broadcast skips the range check because the select is not used for the mask.
    assign start_ok    = start_i && (sel_in_range || bcast_i);
    assign stream_mask = bcast_q ? {NUM_TILES{1'b1}} : (NUM_TILES'(1) << sel_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcast_q <= 1'b0;
        end else if (state_q == StIdle && start_ok) begin
            bcast_q <= bcast_i;
        end
    end
`else
    logic unused_bcast;

    assign unused_bcast = bcast_i;
    assign start_ok     = start_i && sel_in_range;
    assign stream_mask  = NUM_TILES'(1) << sel_q;
`endif

    // Index of the bit presented next cycle, split into word and bit-in-word.
    assign bcnt_nxt = bcnt_q + BcntW'(1);
    assign nxt_bit  = bcnt_nxt[BitW-1:0];
    assign nxt_word = bcnt_nxt[BcntW-1:BitW];

    // Image storage; intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == StFill && word_valid_i && !abort_i) begin
            buf_q[wcnt_q] <= word_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            bcnt_q       <= '0;
            sel_q        <= '0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pm_q         <= '0;
            jtag_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q      <= StFill;
                        wcnt_q       <= '0;
                        sel_q        <= tile_sel_i;
                        word_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StFill: begin
                    if (abort_i) begin
                        state_q      <= StIdle;
                        word_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (word_valid_i) begin
                        wcnt_q <= wcnt_q + WcntW'(1);
                        if (wcnt_q == LastWord) begin
                            // Word 0 is already stored, so bit 0 can be registered now.
                            state_q      <= StStream;
                            bcnt_q       <= '0;
                            word_ready_q <= 1'b0;
                            pm_q         <= stream_mask;
                            jtag_q       <= buf_q[0][0];
                        end
                    end
                end
                StStream: begin
                    if (abort_i || bcnt_q == LastBit) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        pm_q    <= '0;
                        jtag_q  <= 1'b0;
                        done_q  <= !abort_i;
                    end else begin
                        bcnt_q <= bcnt_nxt;
                        jtag_q <= buf_q[nxt_word][nxt_bit];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign word_ready_o    = word_ready_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign program_mode_o  = pm_q;
    assign jtag_data_out_o = jtag_q;

endmodule
